midi_message_decoder: RTL and testbench
=======================================

MIDI_MESSAGE_DECODER -- requirements
Module: midi_message_decoder

Interface
REQ-001 Parameter CHANNEL, default 0, 4-bit MIDI channel accepted when OMNI=0.
REQ-002 Parameter OMNI, default 0, 1 = accept note messages on all 16 channels.
REQ-003 clock_50_000_000  input  1  system clock, all state on rising edge.
REQ-004 reset_l  input  1  asynchronous, active-low reset.
REQ-005 byte_data  input  8  received MIDI byte from the UART receiver.
REQ-006 byte_valid  input  1  one-cycle strobe: byte_data is valid this cycle.
REQ-007 byte_error  input  1  framing error on the byte strobed this cycle; qualified by byte_valid.
REQ-008 note  output  $bits(note_change_t)  decoded note change {status, note_number, velocity}, held until the next decode.
REQ-009 note_ready  output  1  one-cycle pulse: note carries a new decoded event.

Function
REQ-010 The block SHALL be a byte-level FSM with states IDLE (no running status), DATA1, DATA2, SKIP1, SKIP2, SYSEX.
REQ-011 A byte is consumed only in a cycle with byte_valid=1; otherwise state, running status and note are unchanged.
REQ-012 Real-time bytes 0xF8-0xFF SHALL be ignored in every state, with no change to state or running status.
REQ-013 A status byte 0x8n/0x9n with n==CHANNEL (or OMNI=1) SHALL latch it as running status and go to DATA1, from any state.
REQ-014 Other channel-voice status bytes SHALL latch a skip running status: 0xAn/0xBn/0xEn -> SKIP2, 0xCn/0xDn -> SKIP1; this includes 0x8n/0x9n on a non-matching channel, which -> SKIP2.
REQ-015 Byte 0xF0 SHALL clear running status and go to SYSEX; data bytes in SYSEX are discarded; any status byte 0xF1-0xF7 exits to IDLE; a channel-voice status exits per REQ-013/014.
REQ-016 Bytes 0xF1-0xF7 in any state SHALL clear running status and go to IDLE.
REQ-017 Data bytes (bit7=0) in IDLE SHALL be discarded.
REQ-018 DATA1: the data byte SHALL be latched as note_number and the FSM -> DATA2.
REQ-019 DATA2: the data byte is velocity; the FSM SHALL return to DATA1, retaining running status.
REQ-020 SKIP2: data byte -> SKIP1; SKIP1: data byte -> the skip state named by running status (SKIP1 or SKIP2), retaining running status.
REQ-021 On the DATA2 byte, note SHALL update and note_ready SHALL assert on the next clock edge (1-cycle latency), for exactly one cycle.
REQ-022 Decode: 0x9n with velocity>0 -> status ON; 0x9n with velocity 0 -> OFF, velocity 0; 0x8n -> OFF, velocity = received release velocity.
REQ-023 A status byte arriving in DATA2 SHALL abandon the partial message with no note_ready.
REQ-024 byte_valid with byte_error=1 SHALL discard the byte, clear running status and go to IDLE; no note_ready.
REQ-025 note_ready SHALL never assert on two consecutive cycles; back-to-back complete messages produce separate pulses.

Reset
REQ-026 While reset_l=0: state IDLE, running status cleared, note.status=OFF, note_number=0, velocity=0, note_ready=0.
REQ-027 Reset asserted mid-message SHALL discard the partial message; after release the first accepted byte must be a status byte.

Structure
REQ-028 note_change_t, status_t (ON/OFF), note_t, velocity_t and DATA_WIDTH=7 SHALL come from the shared MIDI package; status nibble constants (NOTE_OFF=0x8, NOTE_ON=0x9, SYSEX_START=0xF0, REALTIME_MIN=0xF8) SHALL be added there.
REQ-029 No sub-module; the FSM state enum SHALL be local to the module.
REQ-030 note and note_ready SHALL be registered outputs, directly consumable by the polyphony dispatcher.

Verification
REQ-031 Bytes 0x90,0x3C,0x64 (CHANNEL=0) -> one note_ready pulse, note={ON,60,100}, one cycle after the 0x64 strobe.
REQ-032 Running status 0x90,0x3C,0x64,0x40,0x00 -> two pulses: {ON,60,100} then {OFF,64,0}.
REQ-033 0x80,0x3C,0x40 then 0x91,0x3C,0x64 with CHANNEL=0 -> first {OFF,60,64}; second no pulse; repeat with OMNI=1 -> {ON,60,100} also produced.
REQ-034 0x90,0xF8,0x3C,0xFE,0x64 -> single {ON,60,100}; 0xB0,0x07,0x7F,0x3C,0x64 -> no pulse.
REQ-035 0xF0,0x3C,0x64,0xF7,0x3C,0x64 -> no pulse; 0x90,0x3C,<0x64 with byte_error> -> no pulse, then 0x3C,0x64 -> no pulse.
REQ-036 Reset asserted after 0x90,0x3C, released, then 0x64 -> no pulse; outputs at reset = {OFF,0,0}, note_ready=0.

Source files
------------

// File: rtl/midi_message_decoder_pkg.sv
// Shared MIDI types: decoded note payload and status byte constants.
package midi_message_decoder_pkg;

  localparam int unsigned DATA_WIDTH = 7;

  typedef logic [DATA_WIDTH-1:0] note_t;
  typedef logic [DATA_WIDTH-1:0] velocity_t;

  typedef enum logic {
    STATUS_OFF = 1'b0,
    STATUS_ON  = 1'b1
  } status_t;

  typedef struct packed {
    status_t   status;
    note_t     note_number;
    velocity_t velocity;
  } note_change_t;

  localparam int unsigned NOTE_W = $bits(note_change_t);

  // Status nibbles (upper four bits of a status byte)
  localparam logic [3:0] NOTE_OFF         = 4'h8;
  localparam logic [3:0] NOTE_ON          = 4'h9;
  localparam logic [3:0] POLY_PRESSURE    = 4'hA;
  localparam logic [3:0] CONTROL_CHANGE   = 4'hB;
  localparam logic [3:0] PROGRAM_CHANGE   = 4'hC;
  localparam logic [3:0] CHANNEL_PRESSURE = 4'hD;
  localparam logic [3:0] PITCH_BEND       = 4'hE;

  // Full status bytes
  localparam logic [7:0] SYSEX_START  = 8'hF0;
  localparam logic [7:0] REALTIME_MIN = 8'hF8;

endpackage

// File: rtl/midi_message_decoder.sv
// Byte-level MIDI decoder: extracts note on/off events for one channel
// (or all channels in omni mode), honouring running status.
module midi_message_decoder
  import midi_message_decoder_pkg::*;
#(
  parameter logic [3:0] CHANNEL = 4'h0,
  parameter bit         OMNI    = 1'b0
) (
  input  logic              clock_50_000_000,
  input  logic              reset_l,
  input  logic [7:0]        byte_data,
  input  logic              byte_valid,
  input  logic              byte_error,
  output logic [NOTE_W-1:0] note,
  output logic              note_ready
);

  typedef enum logic [2:0] {
    IDLE, DATA1, DATA2, SKIP1, SKIP2, SYSEX
  } state_t;

  // Running status: which kind of message the following data bytes belong to
  typedef enum logic [2:0] {
    RS_NONE, RS_NOTE_OFF, RS_NOTE_ON, RS_SKIP1, RS_SKIP2
  } run_t;

  state_t       state_q, state_d;
  run_t         run_q, run_d;
  note_t        note_num_q, note_num_d;
  note_change_t note_q, note_d;
  logic         note_ready_q, note_ready_d;

  logic [3:0]            status_hi;
  logic [3:0]            status_lo;
  logic [DATA_WIDTH-1:0] data_byte;
  logic                  chan_match;

  assign status_hi  = byte_data[7:4];
  assign status_lo  = byte_data[3:0];
  assign data_byte  = byte_data[DATA_WIDTH-1:0];
  assign chan_match = OMNI || (status_lo == CHANNEL);

  // Next-state, running status and decoded note for the byte presented this cycle
  always_comb begin
    state_d      = state_q;
    run_d        = run_q;
    note_num_d   = note_num_q;
    note_d       = note_q;
    note_ready_d = 1'b0;

    if (byte_valid) begin
      if (byte_error) begin
        state_d = IDLE;
        run_d   = RS_NONE;
      end else if (byte_data < REALTIME_MIN) begin
        if (byte_data[7]) begin
          case (status_hi)
            NOTE_OFF, NOTE_ON: begin
              if (chan_match) begin
                run_d   = (status_hi == NOTE_ON) ? RS_NOTE_ON : RS_NOTE_OFF;
                state_d = DATA1;
              end else begin
                run_d   = RS_SKIP2;
                state_d = SKIP2;
              end
            end
            POLY_PRESSURE, CONTROL_CHANGE, PITCH_BEND: begin
              run_d   = RS_SKIP2;
              state_d = SKIP2;
            end
            PROGRAM_CHANGE, CHANNEL_PRESSURE: begin
              run_d   = RS_SKIP1;
              state_d = SKIP1;
            end
            default: begin
              run_d   = RS_NONE;
              state_d = (byte_data == SYSEX_START) ? SYSEX : IDLE;
            end
          endcase
        end else begin
          case (state_q)
            DATA1: begin
              note_num_d = data_byte;
              state_d    = DATA2;
            end
            DATA2: begin
              // Note-on with zero velocity is a note-off by MIDI convention
              note_d.status      = (run_q == RS_NOTE_ON && data_byte != '0) ? STATUS_ON : STATUS_OFF;
              note_d.note_number = note_num_q;
              note_d.velocity    = data_byte;
              note_ready_d       = 1'b1;
              state_d            = DATA1;
            end
            SKIP2:   state_d = SKIP1;
            SKIP1:   state_d = (run_q == RS_SKIP1) ? SKIP1 : SKIP2;
            default: state_d = state_q;
          endcase
        end
      end
    end
  end

  // State and output registers
  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      state_q      <= IDLE;
      run_q        <= RS_NONE;
      note_num_q   <= '0;
      note_q       <= '{status: STATUS_OFF, note_number: '0, velocity: '0};
      note_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      note_num_q   <= note_num_d;
      note_q       <= note_d;
      note_ready_q <= note_ready_d;
    end
  end

  assign note       = note_q;
  assign note_ready = note_ready_q;

endmodule

// File: tb/tb_midi_message_decoder.sv
// Scoreboard bench: one fixed-channel and one omni decoder fed the same byte
// stream, each checked against a message-level MIDI model.
module tb_midi_message_decoder;
  import midi_message_decoder_pkg::*;

  logic              clock_50_000_000 = 1'b0;
  logic              reset_l;
  logic [7:0]        byte_data;
  logic              byte_valid;
  logic              byte_error;
  logic [NOTE_W-1:0] note0, note1;
  logic              rdy0, rdy1;

  always #10 clock_50_000_000 = ~clock_50_000_000;

  midi_message_decoder #(.CHANNEL(4'h0), .OMNI(1'b0)) dut0 (
    .clock_50_000_000(clock_50_000_000), .reset_l(reset_l),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_error(byte_error),
    .note(note0), .note_ready(rdy0)
  );

  midi_message_decoder #(.CHANNEL(4'h0), .OMNI(1'b1)) dut1 (
    .clock_50_000_000(clock_50_000_000), .reset_l(reset_l),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_error(byte_error),
    .note(note1), .note_ready(rdy1)
  );

  typedef struct {
    logic [NOTE_W-1:0] val;
    int unsigned       cyc;
  } exp_t;

  exp_t              q0[$];
  exp_t              q1[$];
  int                compared   = 0;
  int                mismatched = 0;
  int unsigned       cyc        = 0;
  int                rs[2];
  int                cnt[2];
  int                d0[2];
  int                pulses[2];
  logic              prev_rdy[2];
  logic [NOTE_W-1:0] last[2];

  always @(posedge clock_50_000_000) cyc <= cyc + 1;

  // Message-level model: running status byte plus count of data bytes seen
  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      rs[i]  = -1;
      cnt[i] = 0;
    end
  endfunction

  function automatic void model_step(int b, bit err, int unsigned due);
    for (int i = 0; i < 2; i++) begin
      if (err) begin
        rs[i]  = -1;
        cnt[i] = 0;
      end else if (b >= 'hF8) begin
        // real-time byte: invisible
      end else if (b >= 'h80) begin
        rs[i]  = (b < 'hF0) ? b : -1;
        cnt[i] = 0;
      end else if (rs[i] >= 0) begin
        int hi;
        int need;
        hi   = rs[i] / 16;
        need = (hi == 'hC || hi == 'hD) ? 1 : 2;
        if (cnt[i] == 0) d0[i] = b;
        cnt[i]++;
        if (cnt[i] == need) begin
          cnt[i] = 0;
          if ((hi == 8 || hi == 9) && (i == 1 || (rs[i] % 16) == 0)) begin
            exp_t e;
            e.val = {(hi == 9 && b != 0) ? 1'b1 : 1'b0, 7'(d0[i]), 7'(b)};
            e.cyc = due;
            if (i == 0) q0.push_back(e);
            else        q1.push_back(e);
          end
        end
      end
    end
  endfunction

  task automatic send(input int b, input bit err = 1'b0);
    @(negedge clock_50_000_000);
    byte_data  = 8'(b);
    byte_valid = 1'b1;
    byte_error = err;
    model_step(b, err, cyc + 1);
    @(posedge clock_50_000_000);
    #1;
    byte_valid = 1'b0;
    byte_error = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock_50_000_000);
  endtask

  // Monitor: pop expected events on every pulse, check held value otherwise
  task automatic mon(input int i, input logic rdy, input logic [NOTE_W-1:0] n);
    exp_t e;
    if (rdy) begin
      pulses[i]++;
      compared++;
      if (prev_rdy[i]) begin
        mismatched++;
        $display("FAIL dut%0d back_to_back_pulse at cycle %0d: note_ready high two cycles", i, cyc);
      end
      if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
        mismatched++;
        $display("FAIL dut%0d unexpected_pulse at cycle %0d: got note %h, expected none", i, cyc, n);
      end else begin
        e = (i == 0) ? q0.pop_front() : q1.pop_front();
        if (n !== e.val || cyc != e.cyc) begin
          mismatched++;
          $display("FAIL dut%0d note_event: got %h at cycle %0d, expected %h at cycle %0d",
                   i, n, cyc, e.val, e.cyc);
        end
      end
      last[i] = n;
    end else begin
      compared++;
      if (n !== last[i]) begin
        mismatched++;
        $display("FAIL dut%0d note_held at cycle %0d: got %h, expected %h", i, cyc, n, last[i]);
      end
    end
    prev_rdy[i] = rdy;
  endtask

  always @(negedge clock_50_000_000) begin
    if (reset_l === 1'b1) begin
      mon(0, rdy0, note0);
      mon(1, rdy1, note1);
    end
  end

  task automatic check_drained(input string name);
    idle(3);
    compared++;
    if (q0.size() != 0 || q1.size() != 0) begin
      mismatched++;
      $display("FAIL %s missing_pulse: pending dut0=%0d dut1=%0d, expected 0", name, q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end
  endtask

  task automatic do_reset(input string name);
    check_drained(name);
    @(negedge clock_50_000_000);
    reset_l = 1'b0;
    #1;
    compared++;
    if (note0 !== '0 || note1 !== '0 || rdy0 !== 1'b0 || rdy1 !== 1'b0) begin
      mismatched++;
      $display("FAIL %s reset_outputs: note0=%h note1=%h rdy0=%b rdy1=%b, expected 0", name, note0, note1, rdy0, rdy1);
    end
    model_reset();
    for (int i = 0; i < 2; i++) begin
      last[i]     = '0;
      prev_rdy[i] = 1'b0;
    end
    idle(3);
    reset_l = 1'b1;
  endtask

  task automatic check_pulses(input string name, input int e0, input int e1);
    compared++;
    if (pulses[0] != e0 || pulses[1] != e1) begin
      mismatched++;
      $display("FAIL %s pulse_count: got dut0=%0d dut1=%0d, expected dut0=%0d dut1=%0d",
               name, pulses[0], pulses[1], e0, e1);
    end
  endtask

  function automatic int rand_byte();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 45) return int'($urandom_range(0, 127));
    if (r < 62) return ($urandom_range(8, 9) * 16) + (($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(0, 15)));
    if (r < 74) return (int'($urandom_range(10, 14)) * 16) + int'($urandom_range(0, 15));
    if (r < 77) return 'hF0;
    if (r < 81) return int'($urandom_range('hF1, 'hF7));
    if (r < 89) return int'($urandom_range('hF8, 'hFF));
    return int'($urandom_range(0, 127));
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_l    = 1'b0;
    byte_data  = '0;
    byte_valid = 1'b0;
    byte_error = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      pulses[i]   = 0;
      prev_rdy[i] = 1'b0;
      last[i]     = '0;
    end
    do_reset("power_on");

    // Single note on, then running status with a velocity-0 note off
    send('h90); send('h3C); send('h64);
    check_drained("single_on");
    send('h90); send('h3C); send('h64); send('h40); send('h00);
    check_drained("running_status");

    // Release velocity preserved; channel 1 only seen in omni mode
    send('h80); send('h3C); send('h40);
    send('h91); send('h3C); send('h64);
    check_drained("channel_filter");

    // Real-time bytes interleaved, then a control change that must be skipped
    send('h90); send('hF8); send('h3C); send('hFE); send('h64);
    send('hB0); send('h07); send('h7F); send('h3C); send('h64);
    check_drained("realtime_skip");

    // Sysex swallows data; framing error drops running status
    send('hF0); send('h3C); send('h64); send('hF7); send('h3C); send('h64);
    send('h90); send('h3C); send('h64, 1'b1); send('h3C); send('h64);
    check_drained("sysex_error");

    // Reset mid-message discards the partial note
    send('h90); send('h3C);
    do_reset("mid_reset");
    send('h64);
    check_drained("after_reset");
    check_pulses("directed", 5, 6);

    // Randomized stream with gaps, errors and occasional resets
    for (int k = 0; k < 3000; k++) begin
      send(rand_byte(), ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
      if (k % 700 == 699) do_reset("random_reset");
    end
    check_drained("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
